// File: rtl/rtc_pkg.sv
// Purpose: shared time-field widths, limits, time struct and 12 h mapping for the RTC.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package rtc_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
   } rtc_time_t;

   // 24 h value to 12 h clock face: midnight and noon both read 12.
   function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
      if (h == 5'd0) begin
         return 5'd12;
      end else if (h > 5'd12) begin
         return h - 5'd12;
      end else begin
         return h;
      end
   endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Purpose: synchronise an asynchronous level and emit a 1-cycle pulse on each rising edge.
// Latency: rise_o is high STAGES clocks after the input is first sampled high.
// Backpressure: none; edges closer together than the synchroniser can resolve may merge.
module pulse_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_100MHz_i,
   input  logic reset_i,
   input  logic pulse_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              edge_q;

   // Flops reset high so a level already high at reset release is not seen as an edge.
   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         sync_q <= '1;
         edge_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pulse_i};
         edge_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/rtc_timekeeper.sv
// Purpose: time-of-day + day counter with set handshake, 12/24 h display, carries; alarm when RTC_ALARM_EN is defined.
// Latency: second edge to update SYNC_STAGES+1 clocks; accepted set visible 1 clock after accept.
// Backpressure: set_ready_o drops for one cycle after every accepted set; a set wins over a same-cycle tick.
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int DAY_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_100MHz_i,
   input  logic              reset_i,
   input  logic              seconds_pulse_i,
   input  logic              run_i,
   input  logic              mode_12h_i,
   input  logic              set_valid_i,
   output logic              set_ready_o,
   input  logic [SEC_W-1:0]  set_sec_i,
   input  logic [MIN_W-1:0]  set_min_i,
   input  logic [HOUR_W-1:0] set_hour_i,
   output logic              set_error_o,
`ifdef RTC_ALARM_EN
   input  logic [HOUR_W-1:0] alarm_hour_i,
   input  logic [MIN_W-1:0]  alarm_min_i,
   input  logic              alarm_arm_i,
   input  logic              alarm_clear_i,
   output logic              alarm_o,
`endif
   output logic [SEC_W-1:0]  seconds_o,
   output logic [MIN_W-1:0]  minutes_o,
   output logic [HOUR_W-1:0] hours_o,
   output logic [HOUR_W-1:0] disp_hours_o,
   output logic              pm_o,
   output logic [DAY_W-1:0]  days_o,
   output logic              tick_o,
   output logic              min_carry_o,
   output logic              day_carry_o
);

   localparam logic [0:0] ST_READY = 1'b0;
   localparam logic [0:0] ST_ACK   = 1'b1;

   logic [0:0]       state_q;
   rtc_time_t        time_q;
   rtc_time_t        time_inc;
   rtc_time_t        set_time;
   logic [DAY_W-1:0] days_q;
   logic             mode_q;
   logic             init_q;
   logic             rise;
   logic             accept;
   logic             set_ok;
   logic             tick_apply;
   logic             sec_wrap;
   logic             min_wrap;
   logic             hour_wrap;

   pulse_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_100MHz_i (clk_100MHz_i),
      .reset_i      (reset_i),
      .pulse_i      (seconds_pulse_i),
      .rise_o       (rise)
   );

   assign set_ready_o = (state_q == ST_READY);
   assign accept      = set_valid_i & set_ready_o;
   assign set_ok      = (set_sec_i <= SEC_MAX) && (set_min_i <= MIN_MAX) && (set_hour_i <= HOUR_MAX);
   assign set_time    = '{hour: set_hour_i, min: set_min_i, sec: set_sec_i};
   // A set in the same cycle as a tick takes priority and swallows the tick.
   assign tick_apply  = rise & run_i & ~accept;

   assign sec_wrap  = (time_q.sec == SEC_MAX);
   assign min_wrap  = sec_wrap & (time_q.min == MIN_MAX);
   assign hour_wrap = min_wrap & (time_q.hour == HOUR_MAX);

   // Time one second ahead of the current value, with cascaded wraps.
   always_comb begin
      time_inc      = time_q;
      time_inc.sec  = sec_wrap  ? '0 : time_q.sec + 6'd1;
      time_inc.min  = min_wrap  ? '0 : (sec_wrap ? time_q.min + 6'd1 : time_q.min);
      time_inc.hour = hour_wrap ? '0 : (min_wrap ? time_q.hour + 5'd1 : time_q.hour);
   end

   // Set-channel FSM; resetting into ACK keeps ready low through reset and its first clock.
   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_ACK;
      end else if (state_q == ST_ACK) begin
         state_q <= ST_READY;
      end else if (accept) begin
         state_q <= ST_ACK;
      end
   end

   // Time, day counter and the registered strobes.
   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         time_q      <= '0;
         days_q      <= '0;
         tick_o      <= 1'b0;
         min_carry_o <= 1'b0;
         day_carry_o <= 1'b0;
         set_error_o <= 1'b0;
      end else begin
         tick_o      <= tick_apply;
         min_carry_o <= tick_apply & sec_wrap;
         day_carry_o <= tick_apply & hour_wrap;
         set_error_o <= accept & ~set_ok;
         if (accept) begin
            if (set_ok) begin
               time_q <= set_time;
            end
         end else if (tick_apply) begin
            time_q <= time_inc;
            if (hour_wrap) begin
               days_q <= days_q + DAY_W'(1);
            end
         end
      end
   end

   // Display mode is registered; until the first clock after reset the live input is shown.
   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         mode_q <= 1'b0;
         init_q <= 1'b0;
      end else begin
         mode_q <= mode_12h_i;
         init_q <= 1'b1;
      end
   end

   assign seconds_o    = time_q.sec;
   assign minutes_o    = time_q.min;
   assign hours_o      = time_q.hour;
   assign days_o       = days_q;
   assign pm_o         = (time_q.hour >= 5'd12);
   assign disp_hours_o = (init_q ? mode_q : mode_12h_i) ? to_12h(time_q.hour) : time_q.hour;

`ifdef RTC_ALARM_EN
   // Sticky alarm: only a counted tick landing on hh:mm:00 sets it; a match beats a clear.
   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         alarm_o <= 1'b0;
      end else if (tick_apply && alarm_arm_i && sec_wrap &&
                   (time_inc.hour == alarm_hour_i) && (time_inc.min == alarm_min_i)) begin
         alarm_o <= 1'b1;
      end else if (alarm_clear_i) begin
         alarm_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
module tb_rtc_timekeeper;

   localparam int S  = 2;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          pulse = 1'b1;
   logic          run = 1'b1;
   logic          mode = 1'b0;
   logic          set_valid = 1'b0;
   logic [5:0]    set_sec = '0;
   logic [5:0]    set_min = '0;
   logic [4:0]    set_hour = '0;
   logic          set_ready, set_error;
   logic [5:0]    seconds, minutes;
   logic [4:0]    hours, disp_hours;
   logic          pm, tick, min_carry, day_carry;
   logic [DW-1:0] days;
`ifdef RTC_ALARM_EN
   logic [4:0]    alarm_hour = '0;
   logic [5:0]    alarm_min = '0;
   logic          alarm_arm = 1'b0;
   logic          alarm_clear = 1'b0;
   logic          alarm;
`endif

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   always #5 clk = ~clk;

   rtc_timekeeper #(.DAY_W(DW), .SYNC_STAGES(S)) dut (
      .clk_100MHz_i    (clk),
      .reset_i         (reset_i),
      .seconds_pulse_i (pulse),
      .run_i           (run),
      .mode_12h_i      (mode),
      .set_valid_i     (set_valid),
      .set_ready_o     (set_ready),
      .set_sec_i       (set_sec),
      .set_min_i       (set_min),
      .set_hour_i      (set_hour),
      .set_error_o     (set_error),
`ifdef RTC_ALARM_EN
      .alarm_hour_i    (alarm_hour),
      .alarm_min_i     (alarm_min),
      .alarm_arm_i     (alarm_arm),
      .alarm_clear_i   (alarm_clear),
      .alarm_o         (alarm),
`endif
      .seconds_o       (seconds),
      .minutes_o       (minutes),
      .hours_o         (hours),
      .disp_hours_o    (disp_hours),
      .pm_o            (pm),
      .days_o          (days),
      .tick_o          (tick),
      .min_carry_o     (min_carry),
      .day_carry_o     (day_carry)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: time as seconds-of-day ----------------
   int tod = 0;
   int mdays = 0;
   bit samp [0:S] = '{default: 1'b1};   // pulse level sampled at the last S+1 edges
   bit tick_m = 0, minc_m = 0, dayc_m = 0, err_m = 0, ready_m = 0;
   bit mode_m = 0, init_m = 0, alarm_m = 0;

   always @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         tod = 0; mdays = 0;
         for (int k = 0; k <= S; k++) samp[k] = 1'b1;
         tick_m = 0; minc_m = 0; dayc_m = 0; err_m = 0; ready_m = 0;
         mode_m = 0; init_m = 0; alarm_m = 0;
      end else begin
         bit rise_m, acc, ok, tk;
         rise_m = samp[S-1] && !samp[S];
         acc    = set_valid && ready_m;
         ok     = (set_sec <= 59) && (set_min <= 59) && (set_hour <= 23);
         tk     = rise_m && run && !acc;
         tick_m = tk; minc_m = 0; dayc_m = 0;
         err_m  = acc && !ok;
         if (acc && ok) begin
            tod = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
         end else if (tk) begin
            tod = tod + 1;
            if (tod % 60 == 0) minc_m = 1;
            if (tod == 86400) begin
               tod = 0; dayc_m = 1;
               mdays = (mdays + 1) % (1 << DW);
            end
         end
`ifdef RTC_ALARM_EN
         if (tk && alarm_arm && tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60) alarm_m = 1;
         else if (alarm_clear) alarm_m = 0;
`endif
         ready_m = !acc;
         mode_m  = mode;
         init_m  = 1;
         for (int k = S; k > 0; k--) samp[k] = samp[k-1];
         samp[0] = pulse;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         int h, h12;
         bit me;
         h   = tod / 3600;
         h12 = (h % 12 == 0) ? 12 : h % 12;
         me  = init_m ? mode_m : mode;
         chk("seconds", seconds, tod % 60);
         chk("minutes", minutes, (tod / 60) % 60);
         chk("hours", hours, h);
         chk("days", days, mdays);
         chk("disp_hours", disp_hours, me ? h12 : h);
         chk("pm", pm, h >= 12);
         chk("tick", tick, tick_m);
         chk("min_carry", min_carry, minc_m);
         chk("day_carry", day_carry, dayc_m);
         chk("set_error", set_error, err_m);
         chk("set_ready", set_ready, ready_m);
`ifdef RTC_ALARM_EN
         chk("alarm", alarm, alarm_m);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_set(input int h, input int m, input int s);
      set_hour  = 5'(h);
      set_min   = 6'(m);
      set_sec   = 6'(s);
      set_valid = 1'b1;
      step(1);
      set_valid = 1'b0;
   endtask

   initial begin
      int hold;
      #1 reset_i = 1'b0;
      #3 cmp_en = 1;
      step(2);
      chk("rst_seconds", seconds, 0);
      chk("rst_ready", set_ready, 0);
      chk("rst_disp", disp_hours, 0);
      reset_i = 1'b1;              // released with the pulse input already high
      step(3);
      chk("ready_after_3", set_ready, 1);
      chk("no_tick_high_at_release", seconds, 0);
      pulse = 1'b0;
      step(2);

      // Day rollover from 23:59:58.
      do_set(23, 59, 58);
      chk("set_hours", hours, 23);
      chk("set_seconds", seconds, 58);
      step(1);
      pulse = 1'b1;
      step(2);
      chk("latency_not_yet", seconds, 58);
      step(1);
      chk("tick_59", seconds, 59);
      chk("tick_pulse", tick, 1);
      pulse = 1'b0;
      step(2);
      pulse = 1'b1;
      step(3);
      chk("wrap_hours", hours, 0);
      chk("wrap_seconds", seconds, 0);
      chk("wrap_days", days, 1);
      chk("wrap_min_carry", min_carry, 1);
      chk("wrap_day_carry", day_carry, 1);
      pulse = 1'b0;
      step(3);

      // Out-of-range set.
      do_set(12, 60, 0);
      chk("bad_set_error", set_error, 1);
      chk("bad_set_ready", set_ready, 0);
      chk("bad_set_hours", hours, 0);
      step(1);
      chk("bad_set_error_gone", set_error, 0);
      chk("bad_set_ready_back", set_ready, 1);

      // Set coincident with a qualified tick.
      pulse = 1'b1;
      step(2);
      do_set(5, 6, 7);
      chk("coinc_seconds", seconds, 7);
      chk("coinc_no_tick", tick, 0);
      pulse = 1'b0;
      step(3);

      // Pulse while held.
      run = 1'b0;
      pulse = 1'b1;
      step(4);
      chk("hold_seconds", seconds, 7);
      pulse = 1'b0;
      step(2);
      run = 1'b1;
      step(1);

      // 12 h display.
      mode = 1'b1;
      step(1);
      do_set(0, 0, 0);
      chk("disp_0", disp_hours, 12);
      chk("pm_0", pm, 0);
      step(1);
      do_set(12, 0, 0);
      chk("disp_12", disp_hours, 12);
      chk("pm_12", pm, 1);
      step(1);
      do_set(13, 0, 0);
      chk("disp_13", disp_hours, 1);
      chk("pm_13", pm, 1);
      mode = 1'b0;
      step(1);
      chk("disp_24h_13", disp_hours, 13);

`ifdef RTC_ALARM_EN
      alarm_hour = 5'd7; alarm_min = 6'd30; alarm_arm = 1'b1;
      do_set(7, 29, 59);
      step(1);
      pulse = 1'b1;
      step(3);
      chk("alarm_set", alarm, 1);
      pulse = 1'b0;
      step(5);
      chk("alarm_sticky", alarm, 1);
      alarm_clear = 1'b1;
      step(1);
      alarm_clear = 1'b0;
      chk("alarm_cleared", alarm, 0);
      do_set(7, 30, 0);
      step(1);
      chk("alarm_not_by_set", alarm, 0);
`endif

      // Randomised traffic, checked every cycle by the model.
      hold = 1;
      for (int c = 0; c < 4000; c++) begin
         hold--;
         if (hold == 0) begin
            pulse = ~pulse;
            hold = $urandom_range(1, 5);
         end
         run       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         set_valid = ($urandom_range(0, 11) == 0);
         set_hour  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31))
                   : ($urandom_range(0, 1) != 0 ? 5'd23 : 5'($urandom_range(0, 23)));
         set_min   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63))
                   : ($urandom_range(0, 1) != 0 ? 6'd59 : 6'($urandom_range(0, 59)));
         set_sec   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63))
                   : 6'($urandom_range(50, 59));
`ifdef RTC_ALARM_EN
         alarm_arm   = ($urandom_range(0, 1) != 0);
         alarm_clear = ($urandom_range(0, 19) == 0);
         alarm_hour  = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(0, 23));
         alarm_min   = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(0, 59));
`endif
         step(1);
      end
      set_valid = 1'b0;
      pulse = 1'b0;
      step(3);

      // Asynchronous reset mid-operation.
      do_set(9, 8, 7);
      step(1);
      reset_i = 1'b0;
      #1;
      chk("midrst_seconds", seconds, 0);
      chk("midrst_hours", hours, 0);
      chk("midrst_ready", set_ready, 0);
      step(2);
      reset_i = 1'b1;
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
